// File: rtl/fc_seq_pkg.sv
// Shared types and helpers for the fully-connected layer sequencer.
// The result width is derived from the activation width and the neuron fan-in.
package fc_seq_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    WAIT  = 2'd1,
    CAPT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Neuron result width: full product width plus adder-tree growth.
  function automatic int ow(input int width, input int n);
    return width * 2 + $clog2(n);
  endfunction

endpackage

// File: rtl/fc_in_buf.sv
// Activation register file that feeds the neuron x[] ports in parallel.
// It supports one indexed write per cycle and a single-cycle clear of every entry.
module fc_in_buf
  import fc_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IN    = 128
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              clr,
  input  logic                              wr_en,
  input  logic [((IN > 1) ? $clog2(IN) : 1)-1:0] wr_idx,
  input  logic [WIDTH-1:0]                  wr_data,
  output logic [IN-1:0][WIDTH-1:0]          x_vec
);

  localparam int IW = (IN > 1) ? $clog2(IN) : 1;

  genvar gi;
  generate
    for (gi = 0; gi < IN; gi++) begin : g_ent
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          x_vec[gi] <= '0;
        end else if (clr) begin
          x_vec[gi] <= '0;
        end else if (wr_en && (wr_idx == IW'(gi))) begin
          x_vec[gi] <= wr_data;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/fc_layer_seq.sv
// Sequencer for one fully-connected layer: loads the input vector, waits for the
// combinational neuron trees to settle, captures every result, then streams them out.
module fc_layer_seq
  import fc_seq_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int IN     = 128,
  parameter int OUT    = 10,
  parameter int SETTLE = 2,
  parameter int OWIDTH = ow(WIDTH, IN)
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    flush,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [WIDTH-1:0]                        in_data,
  input  logic                                    in_last,
  output logic [IN-1:0][WIDTH-1:0]                x_vec,
  input  logic [OUT-1:0][OWIDTH-1:0]              z_vec,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [OWIDTH-1:0]                       out_data,
  output logic [((OUT > 1) ? $clog2(OUT) : 1)-1:0] out_idx,
  output logic                                    out_last,
  output logic                                    len_err
);

  localparam int IW  = (IN > 1) ? $clog2(IN) : 1;
  localparam int OIW = (OUT > 1) ? $clog2(OUT) : 1;
  localparam int CW  = $clog2(SETTLE + 1);

  state_t                     state_reg, state_next;
  logic [IW-1:0]              wr_idx_reg, wr_idx_next;
  logic [CW-1:0]              cnt_reg, cnt_next;
  logic [OIW-1:0]             idx_reg, idx_next;
  logic [OUT-1:0][OWIDTH-1:0] z_buf_reg;
  logic                       in_ready_reg;
  logic                       len_err_reg, len_err_next;
  logic                       wr_en, clr, capt;
  logic                       in_hs, out_hs;

  fc_in_buf #(
    .WIDTH (WIDTH),
    .IN    (IN)
  ) u_in_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx_reg),
    .wr_data (in_data),
    .x_vec   (x_vec)
  );

  assign in_hs  = in_valid && in_ready_reg;
  assign out_hs = out_valid && out_ready;

  always_comb begin
    state_next   = state_reg;
    wr_idx_next  = wr_idx_reg;
    cnt_next     = cnt_reg;
    idx_next     = idx_reg;
    len_err_next = 1'b0;
    wr_en        = 1'b0;
    clr          = 1'b0;
    capt         = 1'b0;
    case (state_reg)
      LOAD: begin
        cnt_next = '0;
        if (in_hs) begin
          wr_en       = 1'b1;
          wr_idx_next = wr_idx_reg + 1'b1;
          if (wr_idx_reg == IW'(IN - 1)) begin
            state_next = WAIT;
          end else if (in_last) begin
            state_next   = WAIT;
            len_err_next = 1'b1;
          end
        end
      end
      // Counter runs 0..SETTLE, giving the neuron trees margin beyond SETTLE cycles.
      WAIT: begin
        if (cnt_reg == CW'(SETTLE)) begin
          state_next = CAPT;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      CAPT: begin
        capt       = 1'b1;
        idx_next   = '0;
        state_next = DRAIN;
      end
      DRAIN: begin
        if (out_hs) begin
          if (idx_reg == OIW'(OUT - 1)) begin
            state_next  = LOAD;
            clr         = 1'b1;
            wr_idx_next = '0;
            idx_next    = '0;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      default: state_next = LOAD;
    endcase
    if (flush) begin
      state_next   = LOAD;
      clr          = 1'b1;
      wr_en        = 1'b0;
      capt         = 1'b0;
      wr_idx_next  = '0;
      idx_next     = '0;
      cnt_next     = '0;
      len_err_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= LOAD;
      wr_idx_reg   <= '0;
      cnt_reg      <= '0;
      idx_reg      <= '0;
      in_ready_reg <= 1'b0;
      len_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wr_idx_reg   <= wr_idx_next;
      cnt_reg      <= cnt_next;
      idx_reg      <= idx_next;
      in_ready_reg <= (state_next == LOAD);
      len_err_reg  <= len_err_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_buf_reg <= '0;
    end else if (flush) begin
      z_buf_reg <= '0;
    end else if (capt) begin
      z_buf_reg <= z_vec;
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = (state_reg == DRAIN);
  assign out_idx   = idx_reg;
  assign out_data  = z_buf_reg[idx_reg];
  assign out_last  = out_valid && (idx_reg == OIW'(OUT - 1));
  assign len_err   = len_err_reg;

endmodule
